// File: rtl/csa_pkg.sv
// Shared types and default sizing for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESOLVE,
    DONE
  } state_t;

  localparam int unsigned W_DEF   = 16;
  localparam int unsigned ACC_EXT = 8;
  localparam int unsigned AW_DEF  = W_DEF + ACC_EXT;
  localparam int unsigned CW_DEF  = 8;

endpackage

// File: rtl/csa_row.sv
// One row of independent full adders: reduces three N-bit vectors to a sum and a carry vector.
module csa_row
  import csa_pkg::*;
#(
  parameter int unsigned N = AW_DEF
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  always_comb begin
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/csa_acc.sv
// Carry-save accumulator with a single carry-propagate resolve step and valid/ready result handoff.
// Define CSA_ACC_SIGNED_EN to sign-extend operands (two's-complement result); default is zero-extension.
module csa_acc
  import csa_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned AW = W + ACC_EXT,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  operand_i,
  input  logic          flush_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [AW-1:0] result_o,
  output logic [CW-1:0] count_o
  ,output logic         busy_o
);

  state_t        state_q, state_d;
  logic [AW-1:0] sum_q, carry_q;
  logic [AW-1:0] ext_op, carry_sh, csa_s, csa_c;
  logic          accept;

`ifdef CSA_ACC_SIGNED_EN
  assign ext_op = {{(AW-W){operand_i[W-1]}}, operand_i};
`else
  assign ext_op = {{(AW-W){1'b0}}, operand_i};
`endif

  // Carry is stored unshifted; its top bit falls off here (mod 2^AW).
  assign carry_sh = {carry_q[AW-2:0], 1'b0};

  csa_row #(.N(AW)) u_row (
    .x(ext_op),
    .y(sum_q),
    .z(carry_sh),
    .s(csa_s),
    .c(csa_c)
  );

  assign in_ready_o  = (state_q == ACC);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == ACC) || (state_q == RESOLVE);
  assign accept      = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = ACC;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACC:     if (flush_i) state_d = RESOLVE;
        RESOLVE: state_d = DONE;
        DONE:    if (res_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sum_q    <= '0;
      carry_q  <= '0;
      count_o  <= '0;
      result_o <= '0;
    end else if (start_i) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_o <= '0;
    end else begin
      if (accept) begin
        sum_q   <= csa_s;
        carry_q <= csa_c;
        count_o <= count_o + CW'(1);
      end
      if (state_q == RESOLVE) result_o <= sum_q + carry_sh;
    end
  end

endmodule

// File: doc/csa_acc.md
CSA_ACC -- requirements
Module: csa_acc

Interface
REQ-001 SHALL have parameter W, default 16, operand width in bits.
REQ-002 SHALL have parameter AW, default W+8, accumulator and result width; AW >= W+1.
REQ-003 SHALL have parameter CW, default 8, operand-count width.
REQ-004 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_i, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, clears the accumulation and begins a new one.
REQ-007 SHALL have port in_valid_i, input, 1, operand_i is valid.
REQ-008 SHALL have port in_ready_o, output, 1, block accepts an operand.
REQ-009 SHALL have port operand_i, input, W, operand to accumulate.
REQ-010 SHALL have port flush_i, input, 1, requests carry-propagate resolution.
REQ-011 SHALL have port res_valid_o, output, 1, result_o is valid.
REQ-012 SHALL have port res_ready_i, input, 1, consumer takes the result.
REQ-013 SHALL have port result_o, output, AW, resolved sum.
REQ-014 SHALL have port count_o, output, CW, operands accepted since the last start.
REQ-015 SHALL have port busy_o, output, 1, high in ACC or RESOLVE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACC, RESOLVE and DONE.
REQ-017 SHALL, on start_i in any state, go to ACC and in the same edge clear sum_q, carry_q and count_o, and drop res_valid_o; start_i overrides every other input.
REQ-018 SHALL drive in_ready_o = 1 only in ACC.
REQ-019 SHALL, on an accepted operand (in_valid_i & in_ready_o), update the state via a per-bit 3:2 compressor of {ext(operand_i), sum_q, carry_q<<1}: sum_q <= s, carry_q <= c, and count_o increments.
REQ-020 SHALL perform all AW-bit arithmetic modulo 2^AW; the carry bit shifted out of bit AW-1 is discarded.
REQ-021 SHALL wrap count_o modulo 2^CW.
REQ-022 SHALL, on flush_i in ACC, go to RESOLVE; a same-cycle accepted operand SHALL be included in the result.
REQ-023 SHALL, in RESOLVE, register result_o <= sum_q + (carry_q<<1) (AW bits) with a single-cycle carry-propagate add, then go to DONE.
REQ-024 SHALL have a latency of exactly 2 cycles from the flush edge to res_valid_o = 1.
REQ-025 SHALL hold res_valid_o = 1 in DONE, with result_o stable, until res_ready_i = 1; it SHALL then go to IDLE and drop res_valid_o on that edge.
REQ-026 SHALL ignore flush_i outside ACC, and ignore in_valid_i outside ACC.
REQ-027 SHALL hold result_o at its last value in IDLE and ACC; only RESOLVE writes it.
REQ-028 SHALL resolve a flush with zero accepted operands to result_o = 0.

Reset
REQ-029 SHALL, with reset_i = 0 at a clock edge, set state to IDLE, set sum_q, carry_q, result_o and count_o to 0, and set res_valid_o, in_ready_o and busy_o to 0.
REQ-030 SHALL let reset_i = 0 abort any state, including mid-accumulation and a pending DONE; the result is lost.
REQ-031 SHALL give reset_i priority over start_i.

Configuration
REQ-032 SHALL use macro CSA_ACC_SIGNED_EN; when defined, ext() sign-extends operand_i from W to AW and result_o is two's complement.
REQ-033 SHALL, without CSA_ACC_SIGNED_EN, zero-extend operand_i from W to AW (ext()); result_o is unsigned.

Structure
REQ-034 SHALL place the state enum type and the default W/AW/CW constants in the shared package csa_pkg.
REQ-035 SHALL build the 3:2 row as sub-module csa_row, parameter N, inputs x/y/z [N-1:0], outputs s/c [N-1:0], per-bit full adder; csa_acc SHALL instantiate it with N = AW.

Verification
REQ-036 SHALL cover: reset, start, operands 3,5,7, flush -> res_valid_o 2 cycles after flush, result_o = 15, count_o = 3.
REQ-037 SHALL cover: 256 operands of 0xFFFF, W=16, AW=24 -> result_o = 0xFFFF00, count_o = 0 (wrap).
REQ-038 SHALL cover: operand and flush in the same cycle after operands 10,20 with operand 30 -> result_o = 60.
REQ-039 SHALL cover: res_ready_i held 0 for 5 cycles -> res_valid_o and result_o stable for all 5; release -> IDLE next edge.
REQ-040 SHALL cover: reset_i = 0 in ACC after 2 operands, then start, operand 4, flush -> result_o = 4, count_o = 1.
REQ-041 SHALL cover, with CSA_ACC_SIGNED_EN: operands 0xFFFF, 0xFFFE (W=16, AW=24) -> result_o = 0xFFFFFD (-3); without the macro -> 0x01FFFD.
